voice_allocator: RTL and testbench

//  Polyphonic voice allocator: maps NUM_NOTES note gates onto NUM_VOICES voice slots.

---
 rtl/voice_allocator_if.sv | 30 +++
 rtl/voice_allocator.sv | 114 +++++++++++
 tb/tb_voice_allocator.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: note gate/phase inputs and per-voice outputs of the voice allocator
// master drives phase_in/gate_in and observes the voice outputs; slave is the allocator side.
interface voice_allocator_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int NUM_NOTES   = 24,
  parameter int NUM_VOICES  = 8
);
  localparam int NW = $clog2(NUM_NOTES);
  localparam int CW = $clog2(NUM_VOICES + 1);
  logic [NUM_NOTES-1:0][PHASE_WIDTH-1:0] phase_in;
  logic [NUM_NOTES-1:0]                  gate_in;
  logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0] addr_out;
  logic [NUM_VOICES-1:0]                 voice_valid_out;
  logic [NUM_VOICES-1:0][NW-1:0]         voice_note_out;
  logic [NUM_VOICES-1:0]                 voice_start_out;
  logic [NUM_NOTES-1:0]                  note_active_out;
  logic [CW-1:0]                         num_voices_out;
  logic                                  dropped_out;
  modport master (
    output phase_in, gate_in,
    input  addr_out, voice_valid_out, voice_note_out, voice_start_out,
           note_active_out, num_voices_out, dropped_out
  );
  modport slave (
    input  phase_in, gate_in,
    output addr_out, voice_valid_out, voice_note_out, voice_start_out,
           note_active_out, num_voices_out, dropped_out
  );
endinterface

// File: rtl/voice_allocator.sv
// voice_allocator: maps NUM_NOTES note gates onto NUM_VOICES slots, stealing the oldest when full
// Ports: clk_in clock, rst_n_in async active-low reset, bus (slave): phase_in/gate_in per note in;
// addr_out, voice_valid_out, voice_note_out, voice_start_out per voice, note_active_out per note,
// num_voices_out popcount of valid slots, dropped_out refusal pulse.
module voice_allocator #(
  parameter int ADDR_WIDTH  = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int NUM_NOTES   = 24,
  parameter int NUM_VOICES  = 8,
  parameter int AGE_WIDTH   = 16,
  parameter bit STEAL_EN    = 1'b1
) (
  input logic clk_in,
  input logic rst_n_in,
  voice_allocator_if.slave bus
);
  localparam int NW = $clog2(NUM_NOTES);
  localparam int CW = $clog2(NUM_VOICES + 1);
  localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  logic [NW-1:0] ptr;
  logic [NUM_VOICES-1:0] valid, valid_n, start, start_n;
  logic [NUM_VOICES-1:0][NW-1:0] note, note_n;
  logic [NUM_VOICES-1:0][AGE_WIDTH-1:0] age, age_n;
  logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0] addr, addr_n;
  logic [NUM_NOTES-1:0] active, active_n, stolen, stolen_n;
  logic [CW-1:0] num, num_n;
  logic drop, drop_n, g, a, s, hit;
  logic [VW-1:0] fi, vi, ri;
  logic [AGE_WIDTH-1:0] best;
  always_comb begin
    g = bus.gate_in[ptr];
    a = active[ptr];
    s = stolen[ptr];
    valid_n = valid;
    note_n = note;
    start_n = '0;
    active_n = active;
    stolen_n = stolen;
    drop_n = 1'b0;
    fi = '0;
    vi = '0;
    ri = '0;
    hit = 1'b0;
    best = '0;
    // descending scan so the last hit is the lowest free index
    for (int i = NUM_VOICES - 1; i >= 0; i--) if (!valid[i]) fi = VW'(i);
    // strict compare keeps the lowest index on equal ages
    for (int i = 0; i < NUM_VOICES; i++)
      if (age[i] > best) begin
        best = age[i];
        vi = VW'(i);
      end
    for (int i = 0; i < NUM_VOICES; i++)
      if (valid[i] && note[i] == ptr) begin
        hit = 1'b1;
        ri = VW'(i);
      end
    if (g && !a && !s) begin
      if (!(&valid)) begin
        valid_n[fi] = 1'b1;
        note_n[fi] = ptr;
        start_n[fi] = 1'b1;
        active_n[ptr] = 1'b1;
      end else if (STEAL_EN) begin
        stolen_n[note[vi]] = 1'b1;
        active_n[note[vi]] = 1'b0;
        note_n[vi] = ptr;
        start_n[vi] = 1'b1;
        active_n[ptr] = 1'b1;
      end else drop_n = 1'b1;
    end else if (!g && a && hit) begin
      valid_n[ri] = 1'b0;
      active_n[ptr] = 1'b0;
    end
    if (!g) stolen_n[ptr] = 1'b0;
    num_n = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      age_n[i] = (!valid_n[i] || start_n[i]) ? '0 : (&age[i] ? age[i] : age[i] + 1'b1);
      addr_n[i] = valid_n[i] ? bus.phase_in[note_n[i]][PHASE_WIDTH-1 -: ADDR_WIDTH] : '0;
      num_n = num_n + CW'(valid_n[i]);
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      ptr <= '0;
      valid <= '0;
      note <= '0;
      start <= '0;
      age <= '0;
      addr <= '0;
      active <= '0;
      stolen <= '0;
      num <= '0;
      drop <= 1'b0;
    end else begin
      ptr <= ptr == NW'(NUM_NOTES - 1) ? '0 : ptr + 1'b1;
      valid <= valid_n;
      note <= note_n;
      start <= start_n;
      age <= age_n;
      addr <= addr_n;
      active <= active_n;
      stolen <= stolen_n;
      num <= num_n;
      drop <= drop_n;
    end
  assign bus.addr_out = addr;
  assign bus.voice_valid_out = valid;
  assign bus.voice_note_out = note;
  assign bus.voice_start_out = start;
  assign bus.note_active_out = active;
  assign bus.num_voices_out = num;
  assign bus.dropped_out = drop;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed checks of a stealing and a dropping allocator fed identical stimulus
module tb_voice_allocator;
  localparam int NN = 24;
  localparam int NV = 8;
  localparam int AW = 8;
  localparam int PW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NN-1:0] gate = '0;
  logic [NN-1:0][PW-1:0] phase = '0;
  logic [63:0] exp_notes, exp_addr;
  logic [7:0] prev;
  logic [7:0] sweep [4] = '{8'h00, 8'h40, 8'h80, 8'hFF};
  int checks = 0;
  int errors = 0;
  int drops;
  always #5 clk = ~clk;
  voice_allocator_if #(.ADDR_WIDTH(AW), .PHASE_WIDTH(PW), .NUM_NOTES(NN), .NUM_VOICES(NV)) bs ();
  voice_allocator_if #(.ADDR_WIDTH(AW), .PHASE_WIDTH(PW), .NUM_NOTES(NN), .NUM_VOICES(NV)) bd ();
  assign bs.gate_in = gate;
  assign bs.phase_in = phase;
  assign bd.gate_in = gate;
  assign bd.phase_in = phase;
  voice_allocator #(.ADDR_WIDTH(AW), .PHASE_WIDTH(PW), .NUM_NOTES(NN), .NUM_VOICES(NV),
    .AGE_WIDTH(16), .STEAL_EN(1'b1)) dut_s (.clk_in(clk), .rst_n_in(rst_n), .bus(bs));
  voice_allocator #(.ADDR_WIDTH(AW), .PHASE_WIDTH(PW), .NUM_NOTES(NN), .NUM_VOICES(NV),
    .AGE_WIDTH(16), .STEAL_EN(1'b0)) dut_d (.clk_in(clk), .rst_n_in(rst_n), .bus(bd));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    edges(2);
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    edges(2);
    check("rst_valid", bs.voice_valid_out, 0);
    check("rst_num", bs.num_voices_out, 0);
    check("rst_active", bs.note_active_out, 0);
    check("rst_start", bs.voice_start_out, 0);
    check("rst_note", bs.voice_note_out, 0);
    check("rst_addr", bs.addr_out, 0);
    check("rst_drop", bd.dropped_out, 0);
    gate = 24'h000008;
    phase[3] = 32'hA5123456;
    do_reset();
    edges(3);
    check("t1_idle", bs.voice_valid_out, 0);
    edges(1);
    check("t1_valid", bs.voice_valid_out, 8'h01);
    check("t1_note", bs.voice_note_out[0], 3);
    check("t1_start", bs.voice_start_out, 8'h01);
    check("t1_num", bs.num_voices_out, 1);
    check("t1_active", bs.note_active_out, 24'h000008);
    check("t1_addr", bs.addr_out, 64'hA5);
    edges(1);
    check("t1_start_once", bs.voice_start_out, 0);
    check("t1_hold", bs.voice_valid_out, 8'h01);
    prev = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      phase[3] = {sweep[i], 24'h0};
      check("t5_lag", bs.addr_out[0], prev);
      edges(1);
      check("t5_track", bs.addr_out[0], sweep[i]);
      prev = sweep[i];
    end
    gate = 24'h0000FF;
    for (int i = 0; i < NN; i++) phase[i] = {8'(8'h10 + i), 24'(i)};
    do_reset();
    edges(7);
    check("t2_valid7", bs.voice_valid_out, 8'h7F);
    check("t2_num7", bs.num_voices_out, 7);
    edges(1);
    exp_notes = '0;
    exp_addr = '0;
    for (int i = 0; i < NV; i++) begin
      exp_notes[i*5 +: 5] = 5'(i);
      exp_addr[i*8 +: 8] = 8'(8'h10 + i);
    end
    check("t2_valid8", bs.voice_valid_out, 8'hFF);
    check("t2_num8", bs.num_voices_out, 8);
    check("t2_notes", bs.voice_note_out, exp_notes);
    check("t2_addr", bs.addr_out, exp_addr);
    check("t2_start", bs.voice_start_out, 8'h80);
    gate[20] = 1'b1;
    edges(12);
    check("t3_pre", bs.voice_start_out, 0);
    edges(1);
    check("t3_note", bs.voice_note_out[0], 20);
    check("t3_start", bs.voice_start_out, 8'h01);
    check("t3_active", bs.note_active_out, 24'h1000FE);
    check("t3_valid", bs.voice_valid_out, 8'hFF);
    check("t4_drop", bd.dropped_out, 1);
    check("t4_active", bd.note_active_out, 24'h0000FF);
    check("t4_start", bd.voice_start_out, 0);
    drops = 0;
    for (int k = 0; k < NN; k++) begin
      edges(1);
      drops += int'(bd.dropped_out);
    end
    check("t4_drop_per_sweep", drops, 1);
    check("t4_drop_edge", bd.dropped_out, 1);
    check("t3_no_realloc", bs.note_active_out, 24'h1000FE);
    check("t3_note_kept", bs.voice_note_out[0], 20);
    gate[5] = 1'b0;
    edges(9);
    check("t2_rel_valid_s", bs.voice_valid_out, 8'hDF);
    check("t2_rel_valid_d", bd.voice_valid_out, 8'hDF);
    check("t2_rel_num", bd.num_voices_out, 7);
    check("t4_rel_active", bd.note_active_out, 24'h0000DF);
    edges(15);
    check("t4_take_note", bd.voice_note_out[5], 20);
    check("t4_take_valid", bd.voice_valid_out, 8'hFF);
    check("t4_take_start", bd.voice_start_out, 8'h20);
    check("t4_take_num", bd.num_voices_out, 8);
    check("t4_take_active", bd.note_active_out, 24'h1000DF);
    check("t3_free_valid", bs.voice_valid_out, 8'hDF);
    check("t3_free_num", bs.num_voices_out, 7);
    gate[0] = 1'b0;
    edges(4);
    check("rel0_valid_d", bd.voice_valid_out, 8'hFE);
    check("rel0_valid_s", bs.voice_valid_out, 8'hDF);
    gate[0] = 1'b1;
    edges(24);
    check("re0_note_s", bs.voice_note_out[5], 0);
    check("re0_start_s", bs.voice_start_out, 8'h20);
    check("re0_valid_s", bs.voice_valid_out, 8'hFF);
    check("re0_note_d", bd.voice_note_out[0], 0);
    check("re0_start_d", bd.voice_start_out, 8'h01);
    gate = 24'h00001F;
    do_reset();
    edges(11);
    check("t6_num5", bs.num_voices_out, 5);
    check("t6_valid5", bs.voice_valid_out, 8'h1F);
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", bs.voice_valid_out, 0);
    check("t6_async_num", bs.num_voices_out, 0);
    check("t6_async_active", bs.note_active_out, 0);
    check("t6_async_note", bs.voice_note_out, 0);
    check("t6_async_addr", bs.addr_out, 0);
    check("t6_async_valid_d", bd.voice_valid_out, 0);
    gate = 24'h000204;
    edges(1);
    rst_n = 1'b1;
    edges(3);
    check("t6_first_note", bs.voice_note_out[0], 2);
    check("t6_first_valid", bs.voice_valid_out, 8'h01);
    edges(7);
    check("t6_second_valid", bs.voice_valid_out, 8'h03);
    check("t6_second_note", bs.voice_note_out[1], 9);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
